reg_sequencer: RTL and testbench

Control sequencer that drives the 3-bit instruction inputs of the datapath registers (X, Y, Z) and the ALU select, one command per clock. It accepts a high-level operation with a `start` strobe and expands it into a timed sequence of HOLD/LOAD/SHIFTR/SHIFTL/RESET commands, including multi-cycle shifts. It reports completion with a one-cycle `done` pulse. It sits between the top-level user/keypad logic and the register/ALU datapath.

---
 rtl/reg_sequencer_pkg.sv | 32 +++
 rtl/reg_sequencer_if.sv | 26 ++
 rtl/reg_sequencer.sv | 98 +++++++++
 tb/tb_reg_sequencer.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/reg_sequencer_pkg.sv
// Shared encodings for the register sequencer: register commands, user ops, FSM states.
// Pure constants and one helper; no logic of its own.
package reg_ctrl_pkg;

  localparam logic [2:0] CMD_HOLD   = 3'b000;
  localparam logic [2:0] CMD_LOAD   = 3'b001;
  localparam logic [2:0] CMD_SHIFTR = 3'b010;
  localparam logic [2:0] CMD_SHIFTL = 3'b011;
  localparam logic [2:0] CMD_RESET  = 3'b100;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_CLR = 3'b100;
  localparam logic [2:0] OP_LDX = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LDX   = 3'd1,
    ST_ALU   = 3'd2,
    ST_MOVZ  = 3'd3,
    ST_SHIFT = 3'd4,
    ST_CLR   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  function automatic logic [2:0] shift_cmd(input logic [2:0] op);
    return (op == OP_SHL) ? CMD_SHIFTL : CMD_SHIFTR;
  endfunction

endpackage

// File: rtl/reg_sequencer_if.sv
// Request/command bundle between user logic (master) and the sequencer (slave).
// No flow control beyond start/busy/done; start is ignored while busy.
interface reg_sequencer_if;

  logic       start;
  logic [2:0] op;
  logic [1:0] amount;
  logic [2:0] instrX;
  logic [2:0] instrY;
  logic [2:0] instrZ;
  logic [1:0] aluSel;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, amount,
    input  instrX, instrY, instrZ, aluSel, busy, done, err
  );

  modport slave (
    input  start, op, amount,
    output instrX, instrY, instrZ, aluSel, busy, done, err
  );

endinterface

// File: rtl/reg_sequencer.sv
// Expands one user op into per-cycle X/Y/Z/ALU commands; latency 1..4 cycles to done.
// One op in flight: start is only sampled in IDLE, no queueing.
module reg_sequencer
  import reg_ctrl_pkg::*;
(
  input  logic           clock,
  input  logic           reset_n,
  reg_sequencer_if.slave bus
);

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic [2:0] op_q, op_nxt;
  logic       err_q, err_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
      op_q  <= 3'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      op_q  <= op_nxt;
      err_q <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_q;
    err_nxt   = err_q;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          op_nxt  = bus.op;
          err_nxt = 1'b0;
          case (bus.op)
            OP_ADD, OP_SUB: state_nxt = ST_ALU;
            OP_SHR, OP_SHL: begin
              cnt_nxt   = bus.amount;
              state_nxt = (bus.amount != 2'd0) ? ST_SHIFT : ST_DONE;
            end
            OP_CLR:  state_nxt = ST_CLR;
            OP_LDX:  state_nxt = ST_LDX;
            default: begin
              err_nxt   = 1'b1;
              state_nxt = ST_DONE;
            end
          endcase
        end
      end
      ST_LDX:  state_nxt = ST_DONE;
      ST_ALU:  state_nxt = ST_MOVZ;
      ST_MOVZ: state_nxt = ST_DONE;
      ST_SHIFT: begin
        // counter holds the shifts still to issue, including this cycle's
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = ST_DONE;
      end
      ST_CLR:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.instrX = CMD_HOLD;
    bus.instrY = CMD_HOLD;
    bus.instrZ = CMD_HOLD;
    bus.aluSel = 2'b00;
    bus.busy   = (state != ST_IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state)
      ST_LDX:   bus.instrX = CMD_LOAD;
      ST_ALU: begin
        bus.instrY = CMD_LOAD;
        bus.aluSel = op_q[1:0];
      end
      ST_MOVZ:  bus.instrZ = CMD_LOAD;
      ST_SHIFT: bus.instrZ = shift_cmd(op_q);
      ST_CLR: begin
        bus.instrX = CMD_RESET;
        bus.instrY = CMD_RESET;
        bus.instrZ = CMD_RESET;
      end
      ST_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: per-op expected command traces built from the op rules,
// compared cycle by cycle, with random ops and random start noise while busy.
module tb_reg_sequencer;

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic [2:0] z;
    logic [1:0] alu;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  logic clock;
  logic reset_n;
  int   n_chk  = 0;
  int   n_pass = 0;
  out_t exp_q[$];

  reg_sequencer_if bus ();

  reg_sequencer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic out_t obs();
    return {bus.instrX, bus.instrY, bus.instrZ, bus.aluSel, bus.busy, bus.done, bus.err};
  endfunction

  function automatic out_t mk(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z,
                              input logic [1:0] alu, input logic busy, input logic done,
                              input logic err);
    out_t o;
    o = '{x: x, y: y, z: z, alu: alu, busy: busy, done: done, err: err};
    return o;
  endfunction

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Expected outputs for each cycle after the accepting edge, ending with the IDLE cycle.
  function automatic void model(input logic [2:0] o, input logic [1:0] a);
    logic [1:0] sel;
    exp_q.delete();
    sel = o[1:0];
    case (o)
      3'd0, 3'd1: begin
        exp_q.push_back(mk(3'b000, 3'b001, 3'b000, sel, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b000, 3'b001, 2'b00, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0));
      end
      3'd2, 3'd3: begin
        for (int i = 0; i < int'(a); i++)
          exp_q.push_back(mk(3'b000, 3'b000, (o == 3'd2) ? 3'b010 : 3'b011, 2'b00,
                             1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0));
      end
      3'd4: begin
        exp_q.push_back(mk(3'b100, 3'b100, 3'b100, 2'b00, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0));
      end
      3'd5: begin
        exp_q.push_back(mk(3'b001, 3'b000, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b0));
      end
      default:
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 2'b00, 1'b1, 1'b1, 1'b1));
    endcase
    exp_q.push_back('0);
  endfunction

  // Called at edge+1 in an IDLE cycle; returns at edge+1 in the final IDLE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] a,
                        input bit noise);
    model(o, a);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.amount = a;
    @(posedge clock); #1;
    bus.start  = 1'b0;
    bus.op     = 3'($urandom_range(0, 7));
    bus.amount = 2'($urandom_range(0, 3));
    foreach (exp_q[i]) begin
      check_eq(tag, obs(), exp_q[i]);
      if (i != exp_q.size() - 1) begin
        bus.start  = (noise && exp_q[i].busy) ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.op     = 3'($urandom_range(0, 7));
        bus.amount = 2'($urandom_range(0, 3));
        if (!exp_q[i + 1].busy) bus.start = 1'b0;
        @(posedge clock); #1;
      end
    end
    bus.start = 1'b0;
  endtask

  initial begin
    logic [2:0] ro;
    logic [1:0] ra;
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.amount = 2'd0;
    #1;
    check_eq("reset_state", obs(), 14'd0);
    #12 reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("idle_after_reset", obs(), 14'd0);

    // SHL x3 interrupted by reset in its second shift cycle
    bus.start = 1'b1; bus.op = 3'd3; bus.amount = 2'd3;
    @(posedge clock); #1;
    bus.start = 1'b0;
    check_eq("shl_c1", obs(), mk(3'b000, 3'b000, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0));
    @(posedge clock); #1;
    check_eq("shl_c2", obs(), mk(3'b000, 3'b000, 3'b011, 2'b00, 1'b1, 1'b0, 1'b0));
    reset_n = 1'b0;
    #1;
    check_eq("rst_async", obs(), 14'd0);
    @(posedge clock); #1;
    check_eq("rst_hold", obs(), 14'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    check_eq("rst_no_done", obs(), 14'd0);

    run_op("add_after_rst", 3'd0, 2'd0, 1'b0);
    run_op("sub_noise",     3'd1, 2'd0, 1'b1);
    run_op("shr_2",         3'd2, 2'd2, 1'b0);
    run_op("shl_0",         3'd3, 2'd0, 1'b0);
    run_op("shl_3",         3'd3, 2'd3, 1'b1);
    run_op("clr",           3'd4, 2'd1, 1'b0);
    run_op("ldx",           3'd5, 2'd2, 1'b0);
    run_op("illegal_111",   3'd7, 2'd3, 1'b0);
    run_op("illegal_110",   3'd6, 2'd1, 1'b1);
    run_op("sub_b2b",       3'd1, 2'd0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 2'($urandom_range(0, 3));
      run_op("random", ro, ra, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
